// File: rtl/cva6_rvfi_probe_fifo_pkg.sv
// -----------------------------------------------------------------------------
// cva6_rvfi_probe_fifo_pkg
// Shared types for the RVFI probe FIFO:
//   - rvfi_probe_fifo_policy_e : full-buffer policy (stall commit / drop and count)
//   - rvfi_probe_rec_t         : packed retirement probe record; its width sets
//                                the default record width of the FIFO
//   - policy_from_param        : maps the integer DropOnFull parameter to a policy
// -----------------------------------------------------------------------------
package cva6_rvfi_probe_fifo_pkg;

    typedef enum logic {
        STALL = 1'b0,
        DROP  = 1'b1
    } rvfi_probe_fifo_policy_e;

    // One retired instruction as seen by the tracer. Padded to 256 bits so a
    // record maps onto a whole number of 64-bit words on the DPI side.
    typedef struct packed {
        logic [22:0] rsvd;
        logic [1:0]  mode;
        logic        intr;
        logic        trap;
        logic [4:0]  rd_addr;
        logic [63:0] mem_addr;
        logic [63:0] rd_wdata;
        logic [31:0] insn;
        logic [63:0] pc;
    } rvfi_probe_rec_t;

    localparam int unsigned RVFI_PROBE_REC_W = $bits(rvfi_probe_rec_t);

    function automatic rvfi_probe_fifo_policy_e policy_from_param(input int drop_on_full);
        return (drop_on_full != 0) ? DROP : STALL;
    endfunction

endpackage

// File: rtl/cva6_rvfi_probe_fifo_lane_compact.sv
// -----------------------------------------------------------------------------
// rvfi_lane_compact
// Interprets the per-lane valid vector of one commit group.
//   in_valid_i : per-lane valid, lane 0 oldest
//   wr_ptr_i   : current buffer write pointer
//   n_o        : number of contiguous valid lanes starting at lane 0
//   lane_en_o  : lanes that belong to the contiguous prefix
//   lane_err_o : a valid lane was seen above the first gap (it is ignored)
//   wr_idx_o   : buffer slot each lane would be written to (wr_ptr + lane)
// -----------------------------------------------------------------------------
module rvfi_lane_compact
    import cva6_rvfi_probe_fifo_pkg::*;
#(
    parameter  int unsigned NrPorts = 2,
    parameter  int unsigned Depth   = 8,
    localparam int unsigned PtrW    = $clog2(Depth),
    localparam int unsigned CntBits = PtrW + 1
) (
    input  logic [NrPorts-1:0]           in_valid_i,
    input  logic [PtrW-1:0]              wr_ptr_i,
    output logic [CntBits-1:0]           n_o,
    output logic [NrPorts-1:0]           lane_en_o,
    output logic                         lane_err_o,
    output logic [NrPorts-1:0][PtrW-1:0] wr_idx_o
);

    always_comb begin
        logic gap;
        gap        = 1'b0;
        n_o        = '0;
        lane_en_o  = '0;
        lane_err_o = 1'b0;
        for (int i = 0; i < int'(NrPorts); i++) begin
            if (!in_valid_i[i]) begin
                gap = 1'b1;
            end else if (gap) begin
                lane_err_o = 1'b1;
            end else begin
                lane_en_o[i] = 1'b1;
                n_o          = n_o + CntBits'(1);
            end
        end
    end

    // An enabled lane always has every lower lane enabled, so its slot is
    // simply wr_ptr + lane index; the pointer width gives the modulo wrap.
    for (genvar g = 0; g < int'(NrPorts); g++) begin : g_idx
        assign wr_idx_o[g] = wr_ptr_i + PtrW'(g);
    end

endmodule

// File: rtl/cva6_rvfi_probe_fifo.sv
// -----------------------------------------------------------------------------
// cva6_rvfi_probe_fifo
// Circular buffer between commit-stage probe packing and the RVFI tracer.
// Accepts up to NrPorts records per cycle in program order, drains one per
// cycle with a first-word-fall-through valid/ready handshake.
//   clk_i, rst_i   : clock, synchronous active-high reset
//   clear_i        : flush contents (pointers/count); sticky status kept
//   in_valid_i     : per-lane valid (must be contiguous from lane 0)
//   in_data_i      : per-lane records, lane i at [i*RecW +: RecW]
//   in_ready_o     : group can be accepted (always 1 under the drop policy)
//   out_valid_o    : head record valid
//   out_data_o     : head record
//   out_ready_i    : tracer accepts the head record
//   count_o        : occupancy
//   drop_cnt_o     : saturating count of dropped records
//   overflow_o     : sticky, a drop occurred
//   lane_err_o     : sticky, a non-contiguous valid vector was seen
// -----------------------------------------------------------------------------
module cva6_rvfi_probe_fifo
    import cva6_rvfi_probe_fifo_pkg::*;
#(
    parameter  int unsigned NrPorts    = 2,
    parameter  int unsigned RecW       = RVFI_PROBE_REC_W,
    parameter  int unsigned Depth      = 8,
    parameter  int unsigned DropOnFull = 0,
    parameter  int unsigned CntW       = 32,
    localparam int unsigned PtrW       = $clog2(Depth),
    localparam int unsigned CntBits    = PtrW + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      clear_i,
    input  logic [NrPorts-1:0]        in_valid_i,
    input  logic [NrPorts*RecW-1:0]   in_data_i,
    output logic                      in_ready_o,
    output logic                      out_valid_o,
    output logic [RecW-1:0]           out_data_o,
    input  logic                      out_ready_i,
    output logic [CntBits-1:0]        count_o,
    output logic [CntW-1:0]           drop_cnt_o,
    output logic                      overflow_o,
    output logic                      lane_err_o
);

    localparam rvfi_probe_fifo_policy_e Policy = policy_from_param(int'(DropOnFull));

    function automatic logic [CntW-1:0] sat_add(input logic [CntW-1:0] a,
                                                input logic [CntBits-1:0] b);
        logic [CntW:0] s;
        s = {1'b0, a} + (CntW+1)'(b);
        return s[CntW] ? '1 : s[CntW-1:0];
    endfunction

    logic [RecW-1:0]             r_mem [Depth];
    logic [PtrW-1:0]             r_wr_ptr;
    logic [PtrW-1:0]             r_rd_ptr;
    logic [CntBits-1:0]          r_count;
    logic [CntW-1:0]             r_drop_cnt;
    logic                        r_overflow;
    logic                        r_lane_err;

    logic [CntBits-1:0]          w_n;
    logic [NrPorts-1:0]          w_lane_en;
    logic                        w_lane_err;
    logic [NrPorts-1:0][PtrW-1:0] w_wr_idx;
    logic [CntBits-1:0]          w_free;
    logic                        w_has;
    logic                        w_room_grp;
    logic                        w_fits;
    logic                        w_in_ready;
    logic                        w_push;
    logic                        w_drop;
    logic                        w_pop;
    logic [CntBits-1:0]          w_count_next;

    rvfi_lane_compact #(
        .NrPorts (NrPorts),
        .Depth   (Depth)
    ) u_lane_compact (
        .in_valid_i (in_valid_i),
        .wr_ptr_i   (r_wr_ptr),
        .n_o        (w_n),
        .lane_en_o  (w_lane_en),
        .lane_err_o (w_lane_err),
        .wr_idx_o   (w_wr_idx)
    );

    // Free space comes from the registered count only: a same-cycle pop never
    // makes room for a push, which keeps out_ready_i off the in_ready_o path.
    assign w_free     = CntBits'(Depth) - r_count;
    assign w_has      = (w_n != '0);
    assign w_room_grp = (w_free >= CntBits'(NrPorts));
    assign w_fits     = (w_n <= w_free);

    always_comb begin
        w_in_ready = 1'b1;
        w_push     = 1'b0;
        w_drop     = 1'b0;
        if (Policy == STALL) begin
            w_in_ready = w_room_grp;
            w_push     = w_room_grp & w_has;
        end else begin
            // Whole group or nothing: a partial push would split an
            // instruction group and confuse the tracer's ordering.
            w_push = w_has & w_fits;
            w_drop = w_has & ~w_fits;
        end
    end

    assign w_pop        = (r_count != '0) & out_ready_i;
    assign w_count_next = r_count + (w_push ? w_n : '0) - (w_pop ? CntBits'(1) : '0);

    // Control state
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_drop_cnt <= '0;
            r_overflow <= 1'b0;
            r_lane_err <= 1'b0;
        end else begin
            if (clear_i) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + w_n[PtrW-1:0];
                if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
                r_count <= w_count_next;
            end
            if (w_drop) begin
                r_drop_cnt <= sat_add(r_drop_cnt, w_n);
                r_overflow <= 1'b1;
            end
            if (w_lane_err) r_lane_err <= 1'b1;
        end
    end

    // Storage (not reset; a slot is only read after it has been written)
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < int'(NrPorts); i++) begin
            if (w_push && w_lane_en[i]) begin
                r_mem[w_wr_idx[i]] <= in_data_i[i*RecW +: RecW];
            end
        end
    end

    assign in_ready_o  = w_in_ready;
    assign out_valid_o = (r_count != '0);
    assign out_data_o  = r_mem[r_rd_ptr];
    assign count_o     = r_count;
    assign drop_cnt_o  = r_drop_cnt;
    assign overflow_o  = r_overflow;
    assign lane_err_o  = r_lane_err;

endmodule

// File: tb/tb_cva6_rvfi_probe_fifo.sv
module tb_cva6_rvfi_probe_fifo;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Stall policy, Depth 8
    logic        s_clr = 1'b0;
    logic [1:0]  s_vld = '0;
    logic [63:0] s_din = '0;
    logic        s_rdy;
    logic        s_ov;
    logic [31:0] s_dout;
    logic        s_ordy = 1'b0;
    logic [3:0]  s_cnt;
    logic [31:0] s_drop;
    logic        s_ovf;
    logic        s_lerr;

    // Drop policy, Depth 8
    logic        d_clr = 1'b0;
    logic [1:0]  d_vld = '0;
    logic [63:0] d_din = '0;
    logic        d_rdy;
    logic        d_ov;
    logic [31:0] d_dout;
    logic        d_ordy = 1'b0;
    logic [3:0]  d_cnt;
    logic [31:0] d_drop;
    logic        d_ovf;
    logic        d_lerr;

    // Stall policy, Depth 4 (wrap-around)
    logic        w_clr = 1'b0;
    logic [1:0]  w_vld = '0;
    logic [63:0] w_din = '0;
    logic        w_rdy;
    logic        w_ov;
    logic [31:0] w_dout;
    logic        w_ordy = 1'b0;
    logic [2:0]  w_cnt;
    logic [31:0] w_drop;
    logic        w_ovf;
    logic        w_lerr;

    cva6_rvfi_probe_fifo #(.NrPorts(2), .RecW(32), .Depth(8), .DropOnFull(0), .CntW(32)) u_stall (
        .clk_i(clk), .rst_i(rst), .clear_i(s_clr), .in_valid_i(s_vld), .in_data_i(s_din),
        .in_ready_o(s_rdy), .out_valid_o(s_ov), .out_data_o(s_dout), .out_ready_i(s_ordy),
        .count_o(s_cnt), .drop_cnt_o(s_drop), .overflow_o(s_ovf), .lane_err_o(s_lerr));

    cva6_rvfi_probe_fifo #(.NrPorts(2), .RecW(32), .Depth(8), .DropOnFull(1), .CntW(32)) u_drop (
        .clk_i(clk), .rst_i(rst), .clear_i(d_clr), .in_valid_i(d_vld), .in_data_i(d_din),
        .in_ready_o(d_rdy), .out_valid_o(d_ov), .out_data_o(d_dout), .out_ready_i(d_ordy),
        .count_o(d_cnt), .drop_cnt_o(d_drop), .overflow_o(d_ovf), .lane_err_o(d_lerr));

    cva6_rvfi_probe_fifo #(.NrPorts(2), .RecW(32), .Depth(4), .DropOnFull(0), .CntW(32)) u_wrap (
        .clk_i(clk), .rst_i(rst), .clear_i(w_clr), .in_valid_i(w_vld), .in_data_i(w_din),
        .in_ready_o(w_rdy), .out_valid_o(w_ov), .out_data_o(w_dout), .out_ready_i(w_ordy),
        .count_o(w_cnt), .drop_cnt_o(w_drop), .overflow_o(w_ovf), .lane_err_o(w_lerr));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int g;
        int rcv;
        int cyc;

        // ---------------- reset state ----------------
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_cnt",   64'(s_cnt), 64'd0);
        chk("rst_ov",    64'(s_ov), 64'd0);
        chk("rst_rdy",   64'(s_rdy), 64'd1);
        chk("rst_drop",  64'(s_drop), 64'd0);
        chk("rst_ovf",   64'(s_ovf), 64'd0);
        chk("rst_lerr",  64'(s_lerr), 64'd0);

        // ---------------- 1: stall fill ----------------
        for (int k = 0; k < 4; k++) begin
            chk("fill_rdy_pre", 64'(s_rdy), 64'd1);
            s_vld = 2'b11;
            s_din = {32'(32'hA0 + 2*k + 1), 32'(32'hA0 + 2*k)};
            step();
            chk("fill_cnt", 64'(s_cnt), 64'(2*k + 2));
            chk("fill_rdy", 64'(s_rdy), (2*k + 2 <= 6) ? 64'd1 : 64'd0);
        end
        s_vld = 2'b00;
        chk("full_head", 64'(s_dout), 64'hA0);

        // ---------------- 5a: push+pop at full ----------------
        s_vld  = 2'b11;
        s_din  = {32'hBAD1, 32'hBAD0};
        s_ordy = 1'b1;
        step();
        chk("full_pp_cnt", 64'(s_cnt), 64'd7);
        chk("full_pp_rdy", 64'(s_rdy), 64'd0);
        s_vld = 2'b00;

        // drain, program order L0,L1 per group
        for (int j = 1; j < 8; j++) begin
            chk("drain_ov",   64'(s_ov), 64'd1);
            chk("drain_data", 64'(s_dout), 64'(32'hA0 + j));
            step();
        end
        chk("drain_cnt", 64'(s_cnt), 64'd0);
        chk("drain_ov0", 64'(s_ov), 64'd0);
        s_ordy = 1'b0;

        // ---------------- 5b: push into empty ----------------
        s_vld = 2'b01;
        s_din = {32'h0, 32'hB0};
        step();
        s_vld = 2'b00;
        chk("empty_push_ov",   64'(s_ov), 64'd1);
        chk("empty_push_data", 64'(s_dout), 64'hB0);
        chk("empty_push_cnt",  64'(s_cnt), 64'd1);

        // ---------------- 3: lane contiguity ----------------
        s_vld = 2'b10;
        s_din = {32'hC1, 32'h0};
        step();
        chk("gap_cnt",  64'(s_cnt), 64'd1);
        chk("gap_lerr", 64'(s_lerr), 64'd1);
        s_vld = 2'b01;
        s_din = {32'h0, 32'hC0};
        step();
        s_vld = 2'b00;
        chk("lane0_cnt",   64'(s_cnt), 64'd2);
        chk("lerr_sticky", 64'(s_lerr), 64'd1);

        // clear with simultaneous push and pop
        s_clr  = 1'b1;
        s_vld  = 2'b11;
        s_ordy = 1'b1;
        s_din  = {32'hDEAD, 32'hBEEF};
        step();
        s_clr  = 1'b0;
        s_vld  = 2'b00;
        s_ordy = 1'b0;
        chk("sclr_cnt",  64'(s_cnt), 64'd0);
        chk("sclr_ov",   64'(s_ov), 64'd0);
        chk("sclr_lerr", 64'(s_lerr), 64'd1);
        s_vld = 2'b01;
        s_din = {32'h0, 32'hD0};
        step();
        s_vld = 2'b00;
        chk("post_clr_data", 64'(s_dout), 64'hD0);

        // ---------------- 2: drop policy ----------------
        chk("drop_rdy", 64'(d_rdy), 64'd1);
        for (int k = 0; k < 3; k++) begin
            d_vld = 2'b11;
            d_din = {32'(32'hE0 + 2*k + 1), 32'(32'hE0 + 2*k)};
            step();
        end
        d_vld = 2'b01;
        d_din = {32'h0, 32'hE6};
        step();
        chk("drop_fill_cnt", 64'(d_cnt), 64'd7);
        d_vld = 2'b11;
        d_din = {32'hF1, 32'hF0};
        step();
        chk("drop_cnt7_cnt",  64'(d_cnt), 64'd7);
        chk("drop_cnt7_drop", 64'(d_drop), 64'd2);
        chk("drop_cnt7_ovf",  64'(d_ovf), 64'd1);
        chk("drop_rdy_full",  64'(d_rdy), 64'd1);
        d_vld  = 2'b00;
        d_ordy = 1'b1;
        step();
        d_ordy = 1'b0;
        chk("drop_pop_cnt", 64'(d_cnt), 64'd6);
        d_vld = 2'b11;
        d_din = {32'hE8, 32'hE7};
        step();
        chk("drop_cnt6_push", 64'(d_cnt), 64'd8);
        d_vld = 2'b01;
        d_din = {32'h0, 32'hF2};
        step();
        d_vld = 2'b00;
        chk("drop_third", 64'(d_drop), 64'd3);
        d_ordy = 1'b1;
        repeat (3) step();
        d_ordy = 1'b0;
        chk("drop_cnt5",  64'(d_cnt), 64'd5);
        chk("drop_head",  64'(d_dout), 64'hE4);

        // ---------------- 6: clear then reset ----------------
        d_clr = 1'b1;
        d_vld = 2'b11;
        d_din = {32'hAA, 32'h55};
        step();
        d_clr = 1'b0;
        d_vld = 2'b00;
        chk("dclr_cnt",  64'(d_cnt), 64'd0);
        chk("dclr_ov",   64'(d_ov), 64'd0);
        chk("dclr_drop", 64'(d_drop), 64'd3);
        chk("dclr_ovf",  64'(d_ovf), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("drst_drop", 64'(d_drop), 64'd0);
        chk("drst_ovf",  64'(d_ovf), 64'd0);
        chk("drst_cnt",  64'(d_cnt), 64'd0);
        chk("srst_lerr", 64'(s_lerr), 64'd0);

        // ---------------- 4: wrap-around, Depth 4 ----------------
        g      = 0;
        rcv    = 0;
        cyc    = 0;
        w_ordy = 1'b1;
        while (rcv < 20 && cyc < 300) begin
            if (w_ov) begin
                chk("wrap_data", 64'(w_dout), 64'(32'h100 + rcv));
                rcv++;
            end
            chk("wrap_cnt_le4", 64'(w_cnt <= 3'd4), 64'd1);
            if (g < 10 && w_rdy) begin
                w_vld = 2'b11;
                w_din = {32'(32'h100 + 2*g + 1), 32'(32'h100 + 2*g)};
                g++;
            end else begin
                w_vld = 2'b00;
            end
            step();
            cyc++;
        end
        w_vld  = 2'b00;
        w_ordy = 1'b0;
        chk("wrap_received", 64'(rcv), 64'd20);
        chk("wrap_groups",   64'(g), 64'd10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
